// File: rtl/boot_copier.sv
// Boot image copier: reads WORDS words from boot ROM and writes them to RAM,
// one ROM read then one RAM write per word, then raises a sticky done flag.
module boot_copier #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE = 32'h0001_0000,
  parameter int unsigned WORDS    = 166
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  output logic        o_rom_request,
  output logic [31:0] o_rom_address,
  input  logic [31:0] i_rom_rdata,
  input  logic        i_rom_ready,
  output logic        o_ram_request,
  output logic        o_ram_rw,
  output logic [31:0] o_ram_address,
  output logic [31:0] o_ram_wdata,
  input  logic        i_ram_ready,
  output logic [31:0] o_count,
  output logic        o_done
);

  localparam logic [31:0] LAST_IDX = 32'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        rom_req_q, rom_req_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic        ram_req_q, ram_req_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] count_q, count_d;
  logic        done_q, done_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] idx_inc;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      rom_req_q  <= 1'b0;
      rom_addr_q <= ROM_BASE;
      ram_req_q  <= 1'b0;
      ram_addr_q <= RAM_BASE;
      wdata_q    <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      ram_req_q  <= ram_req_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    ram_req_d  = ram_req_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    done_d     = done_q;
    idx_d      = idx_q;
    idx_inc    = idx_q + 32'd1;

    case (state_q)
      IDLE: begin
        state_d    = READ;
        rom_req_d  = 1'b1;
        rom_addr_d = ROM_BASE;
      end
      READ: begin
        if (i_rom_ready) begin
          wdata_d    = i_rom_rdata;
          rom_req_d  = 1'b0;
          ram_req_d  = 1'b1;
          ram_addr_d = RAM_BASE + {idx_q[29:0], 2'b00};
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (i_ram_ready) begin
          ram_req_d = 1'b0;
          count_d   = count_q + 32'd1;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Next ROM request issued on the same edge the RAM write retires.
            idx_d      = idx_inc;
            rom_addr_d = ROM_BASE + {idx_inc[29:0], 2'b00};
            rom_req_d  = 1'b1;
            state_d    = READ;
          end
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rom_request = rom_req_q;
  assign o_rom_address = rom_addr_q;
  assign o_ram_request = ram_req_q;
  assign o_ram_rw      = ram_req_q;
  assign o_ram_address = ram_addr_q;
  assign o_ram_wdata   = wdata_q;
  assign o_count       = count_q;
  assign o_done        = done_q;

endmodule
